// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register sentinel and the
// pipeline-control run-state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_RUN   = 2'd1,
    RS_DRAIN = 2'd2,
    RS_HALT  = 2'd3
  } run_state_e;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble generation, run/drain/halt
// sequencing and performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [1:0]       run_state,
  output logic [3:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  run_state_e state_q, state_d;
  logic [3:0] halt_stat_q, halt_stat_d;

  logic lu, rt, mp, m_exc, w_exc, running;

  assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp    = (E_icode == I_JXX) && !e_Cnd;
  assign m_exc = is_exc(m_stat);
  assign w_exc = is_exc(W_stat);

  // Defaults are the IDLE controls; reset forces them regardless of state.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RS_RUN, RS_DRAIN: begin
          F_stall  = lu | rt;
          D_stall  = lu;
          D_bubble = mp | (rt & ~lu);
          E_bubble = mp | lu;
          M_bubble = m_exc | w_exc | (state_q == RS_DRAIN);
          W_stall  = w_exc;
        end
        RS_HALT: W_stall = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_stat_d = halt_stat_q;
    unique case (state_q)
      RS_IDLE:  if (start) state_d = RS_RUN;
      RS_RUN:   if (m_exc) state_d = w_exc ? RS_HALT : RS_DRAIN;
      RS_DRAIN: if (w_exc) state_d = RS_HALT;
      default:  ;
    endcase
    // The status that reaches write-back on the entry edge is the one that stopped us.
    if ((state_d == RS_HALT) && (state_q != RS_HALT)) halt_stat_d = W_stat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RS_IDLE;
      halt_stat_q <= S_AOK;
    end else begin
      state_q     <= state_d;
      halt_stat_q <= halt_stat_d;
    end
  end

  assign run_state = state_q;
  assign halt_stat = halt_stat_q;

  assign running = (state_q == RS_RUN) || (state_q == RS_DRAIN);

  pipe_perf_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .clr (reset),
    .en  (running),
    .cnt (cyc_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .clr (reset),
    .en  (running && (W_stat == S_AOK) && (W_icode != I_NOP) && !W_stall),
    .cnt (retire_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .clr (reset),
    .en  (running && lu),
    .cnt (lu_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_mp_cnt (
    .clk (clk),
    .clr (reset),
    .en  (running && mp),
    .cnt (mp_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: hazard vector table with a control
// scoreboard, plus sequences for start, drain/halt, reset and saturation.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam int CNT_W = 4;

  // Control word order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  localparam logic [5:0] CTL_IDLE = 6'b101110;
  localparam logic [5:0] CTL_HALT = 6'b101111;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM;
  logic             e_Cnd;
  logic [3:0]       M_icode, m_stat, W_icode, W_stat;
  logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [1:0]       run_state;
  logic [3:0]       halt_stat;
  logic [CNT_W-1:0] cyc_cnt, retire_cnt, lu_cnt, mp_cnt;
  logic [5:0]       ctl;

  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .D_icode    (D_icode),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .E_icode    (E_icode),
    .E_dstM     (E_dstM),
    .e_Cnd      (e_Cnd),
    .M_icode    (M_icode),
    .m_stat     (m_stat),
    .W_icode    (W_icode),
    .W_stat     (W_stat),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .E_bubble   (E_bubble),
    .M_bubble   (M_bubble),
    .W_stall    (W_stall),
    .run_state  (run_state),
    .halt_stat  (halt_stat),
    .cyc_cnt    (cyc_cnt),
    .retire_cnt (retire_cnt),
    .lu_cnt     (lu_cnt),
    .mp_cnt     (mp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] d_ic, srca, srcb, e_ic, dstm;
    logic       cnd;
    logic [3:0] m_ic, w_ic;
    logic [5:0] ctl;
    logic       lu, mp, ret;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] ctl;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_lu = 0, exp_mp = 0, exp_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [3:0] d_ic, srca, srcb, e_ic, dstm,
                     input logic cnd, input logic [3:0] m_ic, w_ic, input logic [5:0] c,
                     input logic lu, mp, ret);
    vec_t v;
    v.name = name; v.d_ic = d_ic; v.srca = srca; v.srcb = srcb; v.e_ic = e_ic;
    v.dstm = dstm; v.cnd = cnd; v.m_ic = m_ic; v.w_ic = w_ic; v.ctl = c;
    v.lu = lu; v.mp = mp; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic neutral();
    start   = 1'b0;
    D_icode = I_NOP; d_srcA = RNONE; d_srcB = RNONE;
    E_icode = I_NOP; E_dstM = RNONE; e_Cnd = 1'b1;
    M_icode = I_NOP; m_stat = S_AOK;
    W_icode = I_NOP; W_stat = S_AOK;
  endtask

  // Inputs are already driven (after a negedge): queue the expected controls,
  // let them settle, compare, then advance through the next rising edge.
  task automatic cycle(input string name, input logic [5:0] c);
    exp_t e;
    e.name = name; e.ctl = c;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty at %s", name);
    end else begin
      e = sb.pop_front();
      check({e.name, "_ctl"}, {26'd0, ctl}, {26'd0, e.ctl});
    end
    @(posedge clk); #1;
  endtask

  task automatic check_regs(input string tag, input logic [1:0] rs, input logic [3:0] hs);
    check({tag, "_run_state"}, {30'd0, run_state}, {30'd0, rs});
    check({tag, "_halt_stat"}, {28'd0, halt_stat}, {28'd0, hs});
  endtask

  task automatic check_cnts(input string tag, input int c, input int r, input int l, input int m);
    if (c >= 0) check({tag, "_cyc_cnt"}, 32'(cyc_cnt), c);
    check({tag, "_retire_cnt"}, 32'(retire_cnt), r);
    check({tag, "_lu_cnt"},     32'(lu_cnt), l);
    check({tag, "_mp_cnt"},     32'(mp_cnt), m);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    add("neutral",     I_NOP, RNONE, RNONE, I_NOP,    RNONE, 1, I_NOP, I_NOP,  6'b000000, 0, 0, 0);
    add("lu_srcA",     I_NOP, 4'h3,  RNONE, I_MRMOVQ, 4'h3,  1, I_NOP, I_NOP,  6'b110100, 1, 0, 0);
    add("lu_srcB_pop", I_NOP, RNONE, 4'h5,  I_POPQ,   4'h5,  1, I_NOP, I_NOP,  6'b110100, 1, 0, 0);
    add("load_rnone",  I_NOP, RNONE, RNONE, I_MRMOVQ, RNONE, 1, I_NOP, I_NOP,  6'b000000, 0, 0, 0);
    add("load_nomatch",I_NOP, 4'h4,  4'h2,  I_MRMOVQ, 4'h3,  1, I_NOP, I_NOP,  6'b000000, 0, 0, 0);
    add("store_nolu",  I_NOP, 4'h3,  RNONE, I_RMMOVQ, 4'h3,  1, I_NOP, I_NOP,  6'b000000, 0, 0, 0);
    add("ret_in_D",    I_RET, RNONE, RNONE, I_NOP,    RNONE, 1, I_NOP, I_NOP,  6'b101000, 0, 0, 0);
    add("ret_in_E",    I_NOP, RNONE, RNONE, I_RET,    RNONE, 1, I_NOP, I_NOP,  6'b101000, 0, 0, 0);
    add("ret_in_M",    I_NOP, RNONE, RNONE, I_NOP,    RNONE, 1, I_RET, I_NOP,  6'b101000, 0, 0, 0);
    add("ret_D_lu",    I_RET, 4'h3,  RNONE, I_MRMOVQ, 4'h3,  1, I_NOP, I_NOP,  6'b110100, 1, 0, 0);
    add("ret_M_lu",    I_NOP, 4'h3,  RNONE, I_MRMOVQ, 4'h3,  1, I_RET, I_NOP,  6'b110100, 1, 0, 0);
    add("mispredict",  I_NOP, RNONE, RNONE, I_JXX,    RNONE, 0, I_NOP, I_NOP,  6'b001100, 0, 1, 0);
    add("jxx_taken",   I_NOP, RNONE, RNONE, I_JXX,    RNONE, 1, I_NOP, I_NOP,  6'b000000, 0, 0, 0);
    add("mp_ret_D",    I_RET, RNONE, RNONE, I_JXX,    RNONE, 0, I_NOP, I_NOP,  6'b101100, 0, 1, 0);
    add("mp_ret_M",    I_NOP, RNONE, RNONE, I_JXX,    RNONE, 0, I_RET, I_NOP,  6'b101100, 0, 1, 0);
    add("retire_opq",  I_NOP, RNONE, RNONE, I_NOP,    RNONE, 1, I_NOP, I_OPQ,  6'b000000, 0, 0, 1);
    add("retire_halt", I_NOP, RNONE, RNONE, I_NOP,    RNONE, 1, I_NOP, I_HALT, 6'b000000, 0, 0, 1);
    add("retire_lu",   I_NOP, 4'h3,  RNONE, I_MRMOVQ, 4'h3,  1, I_NOP, I_OPQ,  6'b110100, 1, 0, 1);

    // Reset state
    neutral();
    reset = 1'b1;
    #2;
    check("in_reset_ctl", {26'd0, ctl}, {26'd0, CTL_IDLE});
    @(posedge clk); #1;
    check_regs("reset", RS_IDLE, S_AOK);
    check_cnts("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores hazards and holds the idle controls
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      E_icode = I_MRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
      cycle("idle_hold", CTL_IDLE);
    end
    check_regs("idle", RS_IDLE, S_AOK);
    check_cnts("idle", 0, 0, 0, 0);

    // Start pulse
    @(negedge clk);
    neutral();
    start = 1'b1;
    cycle("start_edge", CTL_IDLE);
    start = 1'b0;
    check_regs("after_start", RS_RUN, S_AOK);
    check_cnts("after_start", 0, 0, 0, 0);

    // Hazard table
    foreach (tbl[i]) begin
      @(negedge clk);
      neutral();
      D_icode = tbl[i].d_ic; d_srcA = tbl[i].srca; d_srcB = tbl[i].srcb;
      E_icode = tbl[i].e_ic; E_dstM = tbl[i].dstm; e_Cnd = tbl[i].cnd;
      M_icode = tbl[i].m_ic; W_icode = tbl[i].w_ic;
      cycle(tbl[i].name, tbl[i].ctl);
      exp_lu  += int'(tbl[i].lu);
      exp_mp  += int'(tbl[i].mp);
      exp_ret += int'(tbl[i].ret);
    end
    check_regs("after_table", RS_RUN, S_AOK);
    check_cnts("after_table", -1, exp_ret, exp_lu, exp_mp);

    // Exception in memory: drain, then halt when it reaches write-back
    @(negedge clk);
    neutral();
    W_icode = I_OPQ; m_stat = S_ADR;
    cycle("m_exc", 6'b000010);
    exp_ret++;
    check_regs("drain_entry", RS_DRAIN, S_AOK);

    @(negedge clk);
    neutral();
    W_icode = I_OPQ; E_icode = I_MRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
    cycle("drain_lu", 6'b110110);
    exp_ret++; exp_lu++;
    check_regs("drain_hold", RS_DRAIN, S_AOK);

    @(negedge clk);
    neutral();
    W_icode = I_OPQ; W_stat = S_ADR;
    cycle("w_exc", 6'b000011);
    check_regs("halt_entry", RS_HALT, S_ADR);
    check_cnts("halt_entry", -1, exp_ret, exp_lu, exp_mp);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      neutral();
      start = 1'b1; W_icode = I_OPQ;
      E_icode = I_MRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
      cycle("halt_hold", CTL_HALT);
    end
    check_regs("halt_stays", RS_HALT, S_ADR);
    check_cnts("halt_frozen", -1, exp_ret, exp_lu, exp_mp);

    // Reset from HALT wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1;
    cycle("reset_over_start", CTL_IDLE);
    check_regs("reset_from_halt", RS_IDLE, S_AOK);
    check_cnts("reset_from_halt", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;

    // Exceptions in memory and write-back together: straight to HALT
    @(negedge clk);
    neutral();
    start = 1'b1;
    cycle("restart", CTL_IDLE);
    start = 1'b0;
    check_regs("restart", RS_RUN, S_AOK);
    @(negedge clk);
    neutral();
    m_stat = S_INS; W_stat = S_HLT;
    cycle("run_to_halt", 6'b000011);
    check_regs("direct_halt", RS_HALT, S_HLT);

    // Counter saturation with a 4-bit counter
    @(negedge clk);
    reset = 1'b1;
    neutral();
    cycle("reset2", CTL_IDLE);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    cycle("start3", CTL_IDLE);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      neutral();
      cycle("run_quiet", 6'b000000);
      if (i == 3)  check("cyc_cnt_3",  32'(cyc_cnt), 3);
      if (i == 15) check("cyc_cnt_15", 32'(cyc_cnt), 15);
    end
    check("cyc_cnt_saturated", 32'(cyc_cnt), 15);
    check_regs("sat_end", RS_RUN, S_AOK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 processor. It generates the per-stage stall and bubble controls consumed by the fetch, decode, execute, memory and write-back pipeline registers, covering load/use hazards, `ret` handling and branch mispredict recovery. It also runs a run/drain/halt sequencer and a set of performance counters. It sits beside the stage modules and is the only source of `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble` and `W_stall`.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` input 1: pipeline clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse that leaves IDLE and begins execution.
- `D_icode` input 4: icode held in the decode register.
- `d_srcA`, `d_srcB` input 4 each: decode source register IDs; 0xF means none.
- `E_icode`, `E_dstM` input 4 each: icode and load destination held in the execute register.
- `e_Cnd` input 1: branch condition evaluated in execute.
- `M_icode` input 4: icode held in the memory register.
- `m_stat` input 4: status leaving the memory stage.
- `W_icode`, `W_stat` input 4 each: icode and status held in the write-back register.
- `F_stall`, `D_stall`, `W_stall` output 1 each: hold the corresponding register.
- `D_bubble`, `E_bubble`, `M_bubble` output 1 each: load a nop bubble into the corresponding register.
- `run_state` output 2: 0 = IDLE, 1 = RUN, 2 = DRAIN, 3 = HALT.
- `halt_stat` output 4: status that terminated execution; SAOK until HALT is entered.
- `cyc_cnt`, `retire_cnt`, `lu_cnt`, `mp_cnt` output CNT_W each: performance counters.

## Operation
- Encodings: icodes HALT = 0 through POPQ = 0xB; stat codes SAOK = 1, SHLT = 2, SADR = 3, SINS = 4; RNONE = 0xF.
- Hazard terms are combinational:
  - `lu` (load/use) = E_icode ∈ {MRMOVQ, POPQ} and E_dstM ≠ RNONE and E_dstM ∈ {d_srcA, d_srcB}.
  - `rt` (ret in flight) = IRET ∈ {D_icode, E_icode, M_icode}.
  - `mp` (mispredict) = E_icode = JXX and !e_Cnd.
  - `exc(s)` = s ∈ {SHLT, SADR, SINS}.
- Outputs in RUN:
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (rt & !lu).
  - E_bubble = mp | lu.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
- Simultaneous events:
  - lu with rt: stall F and D, bubble E, D_bubble = 0.
  - mp with rt: D_bubble and E_bubble both asserted.
  - lu with mp cannot occur, because E_icode cannot be both a load and a jump.
- FSM:
  - IDLE: F_stall = 1, D/E/M_bubble = 1, D_stall = W_stall = 0. A `start` pulse moves to RUN; any other input is ignored.
  - RUN: exc(m_stat) moves to DRAIN. If exc(W_stat) is also true in the same cycle, go directly to HALT.
  - DRAIN: the RUN equations still apply, and M_bubble is forced to 1 so no later memory write commits. exc(W_stat) moves to HALT.
  - HALT: F_stall = 1, W_stall = 1, D/E/M_bubble = 1, D_stall = 0. On entry, halt_stat latches W_stat. HALT is left only through `reset`.
  - A `start` pulse outside IDLE is ignored.
- Counters saturate at all-ones and do not wrap. They update only in RUN or DRAIN:
  - cyc_cnt increments every cycle.
  - retire_cnt increments when W_stat = SAOK, W_icode ≠ NOP and !W_stall.
  - lu_cnt increments on cycles with lu.
  - mp_cnt increments on cycles with mp.

## Timing
- Stall and bubble outputs are combinational from the current state and current-cycle inputs. They must settle before the rising edge that acts on them, so there is zero latency.
- `run_state`, `halt_stat` and all counters are registered and change one cycle after the triggering condition.
- Reset values: run_state = IDLE, halt_stat = SAOK, all counters = 0. While `reset` is high, outputs take their IDLE values.
- `reset` overrides `start` in the same cycle.
- Reset asserted in RUN, DRAIN or HALT returns the block to IDLE on the next edge and clears the counters. No drain is performed.

## Structure
- Shared package `y86_pkg`: icode constants, stat constants, RNONE, and the run_state encoding. The stage modules already need these same constants.
- One sub-module, `pipe_perf_cnt`: a parameterised saturating counter with enable and synchronous clear, instantiated four times.
- The hazard equations and the FSM stay inline in `pipe_ctrl`.

## Test plan
- Reset then `start`: IDLE outputs are held until `start`; run_state = 1 the next cycle; all counters read 0 before `start`.
- Load/use: E_icode = MRMOVQ, E_dstM = 3, d_srcA = 3 for one cycle -> F_stall = D_stall = E_bubble = 1, D_bubble = 0; lu_cnt increments by 1.
- Ret: D_icode = IRET -> F_stall = 1, D_bubble = 1, for each of the 3 cycles while ret moves D, E, M; the same cycles combined with lu give D_bubble = 0.
- Mispredict: E_icode = JXX, e_Cnd = 0 -> D_bubble = E_bubble = 1, F_stall = 0; mp_cnt = 1.
- Exception drain: m_stat = SADR -> M_bubble = 1 that cycle and run_state = 2 the next; W_stat = SADR -> run_state = 3, halt_stat = 3, W_stall = 1; retire_cnt freezes; `start` has no effect; `reset` returns to IDLE.
- Counter saturation with CNT_W = 4: after 20 RUN cycles, cyc_cnt = 15.
